// File: rtl/uart_pkg.sv
// Shared UART definitions: one-hot frame states and parity-mode codes,
// used by the transmitter and the receiver.
package uart_pkg;

   // One-hot frame sequencer states
   typedef enum logic [4:0] {
      ST_IDLE   = 5'b00001,
      ST_START  = 5'b00010,
      ST_DATA   = 5'b00100,
      ST_PARITY = 5'b01000,
      ST_STOP   = 5'b10000
   } uart_state_t;

   // Parity-mode selector values; anything else means no parity
   localparam int unsigned PAR_NONE = 32'd0;
   localparam int unsigned PAR_EVEN = 32'd1;
   localparam int unsigned PAR_ODD  = 32'd2;

endpackage

// File: rtl/uart_tx_cfg.sv
// Parametrised UART serialiser: start bit, DBIT data bits LSB first, optional
// parity bit, then SB_TICK oversample ticks of stop. Bit timing is driven by
// the baud generator's s_tick strobe. All line outputs come straight from flops.
module uart_tx_cfg
   import uart_pkg::*;
#(
   parameter int unsigned DBIT    = 8,
   parameter int unsigned OS_TICK = 16,
   parameter int unsigned SB_TICK = 16,
   parameter int unsigned PARITY  = 0
)(
   input  logic            clk,
   input  logic            reset,
   input  logic            s_tick,
   input  logic            tx_start,
   input  logic [DBIT-1:0] din,
   output logic            tx,
   output logic            busy,
   output logic            tx_done_tick
);

   // The tick counter serves both the data-bit period and the stop period
   localparam int unsigned S_MAX = (OS_TICK > SB_TICK) ? OS_TICK : SB_TICK;
   localparam int unsigned SW    = (S_MAX > 32'd1) ? $clog2(S_MAX) : 32'd1;
   localparam int unsigned NW    = (DBIT > 32'd1) ? $clog2(DBIT) : 32'd1;

   localparam logic [SW-1:0] S_ONE       = SW'(1);
   localparam logic [SW-1:0] S_BIT_LAST  = SW'(OS_TICK - 32'd1);
   localparam logic [SW-1:0] S_STOP_LAST = SW'(SB_TICK - 32'd1);
   localparam logic [NW-1:0] N_ONE       = NW'(1);
   localparam logic [NW-1:0] N_LAST      = NW'(DBIT - 32'd1);

   // Unknown parity modes fall back to "no parity"
   localparam logic PAR_EN  = (PARITY == PAR_EVEN) || (PARITY == PAR_ODD);
   localparam logic PAR_INV = (PARITY == PAR_ODD);

   // Even parity is the XOR of the word; odd parity is its complement
   function automatic logic frame_parity(input logic [DBIT-1:0] word);
      return (^word) ^ PAR_INV;
   endfunction

   uart_state_t     state_r;
   logic [SW-1:0]   s_r;
   logic [NW-1:0]   n_r;
   logic [DBIT-1:0] shreg_r;
   logic            par_r;
   logic            tx_r;
   logic            busy_r;
   logic            done_r;

   // Frame sequencer: tx is loaded on the same edge that changes state, so
   // every bit on the line lasts exactly its tick count.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r <= ST_IDLE;
         s_r     <= '0;
         n_r     <= '0;
         shreg_r <= '0;
         par_r   <= 1'b0;
         tx_r    <= 1'b1;
         busy_r  <= 1'b0;
         done_r  <= 1'b0;
      end else begin
         done_r <= 1'b0;
         case (state_r)
            ST_IDLE: begin
               tx_r <= 1'b1;
               if (tx_start) begin
                  shreg_r <= din;
                  par_r   <= frame_parity(din);
                  s_r     <= '0;
                  n_r     <= '0;
                  busy_r  <= 1'b1;
                  tx_r    <= 1'b0;
                  state_r <= ST_START;
               end
            end
            ST_START: begin
               if (s_tick) begin
                  if (s_r == S_BIT_LAST) begin
                     s_r     <= '0;
                     n_r     <= '0;
                     tx_r    <= shreg_r[0];
                     state_r <= ST_DATA;
                  end else begin
                     s_r <= s_r + S_ONE;
                  end
               end
            end
            ST_DATA: begin
               if (s_tick) begin
                  if (s_r == S_BIT_LAST) begin
                     s_r     <= '0;
                     shreg_r <= {1'b0, shreg_r[DBIT-1:1]};
                     if (n_r == N_LAST) begin
                        if (PAR_EN) begin
                           tx_r    <= par_r;
                           state_r <= ST_PARITY;
                        end else begin
                           tx_r    <= 1'b1;
                           state_r <= ST_STOP;
                        end
                     end else begin
                        n_r  <= n_r + N_ONE;
                        tx_r <= shreg_r[1];
                     end
                  end else begin
                     s_r <= s_r + S_ONE;
                  end
               end
            end
            ST_PARITY: begin
               if (s_tick) begin
                  if (s_r == S_BIT_LAST) begin
                     s_r     <= '0;
                     tx_r    <= 1'b1;
                     state_r <= ST_STOP;
                  end else begin
                     s_r <= s_r + S_ONE;
                  end
               end
            end
            ST_STOP: begin
               if (s_tick) begin
                  if (s_r == S_STOP_LAST) begin
                     s_r     <= '0;
                     tx_r    <= 1'b1;
                     busy_r  <= 1'b0;
                     done_r  <= 1'b1;
                     state_r <= ST_IDLE;
                  end else begin
                     s_r <= s_r + S_ONE;
                  end
               end
            end
            default: begin
               s_r     <= '0;
               n_r     <= '0;
               tx_r    <= 1'b1;
               busy_r  <= 1'b0;
               state_r <= ST_IDLE;
            end
         endcase
      end
   end

   assign tx           = tx_r;
   assign busy         = busy_r;
   assign tx_done_tick = done_r;

endmodule
